// File: rtl/serializer_pkg.sv
// -----------------------------------------------------------------------------
// serializer_pkg
// Shared definitions for the multi-lane word serializer:
//   - default-configuration slot count N and slot-counter width CNTW
//   - calc_cntw(): counter width for an arbitrary slot count, max(1, $clog2(n))
//   - PRBS7 (x^7 + x^6 + 1) seed and tap positions for the idle generator
//   - bit-order encoding of the msbFirst input
// Related build macro: SER_IDLE_PRBS_EN (see multi_lane_serializer).
// -----------------------------------------------------------------------------
package serializer_pkg;

    // Default configuration: one 8-bit word on a single lane.
    localparam int SER_WORDWIDTH = 8;
    localparam int SER_LANES     = 1;

    // Width of a counter that must hold the values 0 .. n-1.
    // Never narrower than one bit, so N == 1 still gets a real register.
    function automatic int calc_cntw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int N    = SER_WORDWIDTH / SER_LANES;
    localparam int CNTW = calc_cntw(N);

    // PRBS7, x^7 + x^6 + 1. The state holds the last seven generated bits,
    // index 0 being the newest, so taps 6 and 5 are the bits produced seven
    // and six steps ago.
    localparam int             PRBS7_LEN    = 7;
    localparam logic [6:0]     PRBS7_SEED   = 7'h7F;
    localparam int             PRBS7_TAP_HI = 6;
    localparam int             PRBS7_TAP_LO = 5;

    // Encoding of msbFirst.
    typedef enum logic {
        ORDER_LSB = 1'b0,
        ORDER_MSB = 1'b1
    } bit_order_e;

endpackage : serializer_pkg

// File: rtl/prbs7_word_gen.sv
// -----------------------------------------------------------------------------
// prbs7_word_gen
// Produces WIDTH consecutive PRBS7 (x^7 + x^6 + 1) bits in parallel. Bit i of
// 'word' is the i-th bit the sequence generates after the current state; when
// 'advance' is high the state jumps forward by WIDTH steps at the clock edge.
// Seeded with PRBS7_SEED on reset.
// Ports:
//   clk      in   1      clock
//   reset    in   1      synchronous, active-high reset
//   advance  in   1      consume the current word and step WIDTH bits ahead
//   word     out  WIDTH  next WIDTH PRBS bits, bit 0 generated first
// -----------------------------------------------------------------------------
module prbs7_word_gen
    import serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    output logic [WIDTH-1:0] word
);

    logic [PRBS7_LEN-1:0] state;
    logic [PRBS7_LEN-1:0] state_next;
    logic [PRBS7_LEN-1:0] walk;

    // Unroll WIDTH single-bit LFSR steps into one combinational cloud.
    // NOTE: blocking assignments are deliberate here; each loop iteration must
    // see the state left by the previous one, exactly like a software loop.
    always_comb begin
        walk = state;
        word = '0;
        for (int i = 0; i < WIDTH; i++) begin
            word[i] = walk[PRBS7_TAP_HI] ^ walk[PRBS7_TAP_LO];
            walk    = {walk[PRBS7_LEN-2:0], word[i]};
        end
        state_next = walk;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PRBS7_SEED;
        end else if (advance) begin
            state <= state_next;
        end
    end

endmodule : prbs7_word_gen

// File: rtl/multi_lane_serializer.sv
// -----------------------------------------------------------------------------
// multi_lane_serializer
// Splits each WORDWIDTH-bit word across LANES serial outputs, one LANES-bit
// slice per bitCK, N = WORDWIDTH/LANES slots per word. Words are taken with a
// valid/ready handshake at word boundaries; when nothing is offered an idle
// word is sent instead. Bit order (LSB or MSB first) is latched per word.
//
// Build macro SER_IDLE_PRBS_EN:
//   defined   - idle words come from an internal PRBS7 (seed 7'h7F) that
//               advances WORDWIDTH bits per idle word; idleWord is ignored
//   undefined - idle words are taken from idleWord; no PRBS logic exists
//
// Ports:
//   bitCK       in   1          serial bit clock, the only clock
//   reset       in   1          synchronous, active-high reset
//   enable      in   1          clock enable; all state holds while low
//   din         in   WORDWIDTH  parallel data word
//   din_valid   in   1          din is offered
//   din_ready   out  1          din is taken this cycle (when din_valid)
//   msbFirst    in   1          0 = LSB first, 1 = MSB first; used at load
//   idleWord    in   WORDWIDTH  filler word when no data is offered
//   sout        out  LANES      serial slice, lane k = bit k of the slice
//   wordStart   out  1          first slot of every word on sout
//   wordIsIdle  out  1          all slots of an idle word
// -----------------------------------------------------------------------------
module multi_lane_serializer
    import serializer_pkg::*;
#(
    parameter int WORDWIDTH = 8,
    parameter int LANES     = 1
) (
    input  logic                 bitCK,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [WORDWIDTH-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic                 msbFirst,
    input  logic [WORDWIDTH-1:0] idleWord,
    output logic [LANES-1:0]     sout,
    output logic                 wordStart,
    output logic                 wordIsIdle
);

    localparam int              NSLOT     = WORDWIDTH / LANES;
    localparam int              CW        = calc_cntw(NSLOT);
    localparam logic [CW-1:0]   LAST_SLOT = CW'(NSLOT - 1);

    if ((LANES < 1) || ((WORDWIDTH % LANES) != 0)) begin : g_bad_cfg
        $error("multi_lane_serializer: WORDWIDTH must be a multiple of LANES");
    end

    logic [CW-1:0]        cnt;        // slot index of the word now on sout
    logic [WORDWIDTH-1:0] r;          // shift register, output slice at one end
    bit_order_e           mode;       // bit order latched at load
    logic                 idle_q;     // word on sout is an idle word
    logic                 primed;     // a word has been loaded since reset
    logic [WORDWIDTH-1:0] idle_src;
    logic                 at_boundary;
    logic                 load;
    logic                 transfer;

    // The last slot of a word doubles as the load slot, so the next word
    // follows without a gap. Reset parks cnt there: the first enabled edge
    // after reset loads.
    assign at_boundary = (cnt == LAST_SLOT);
    assign load        = enable & at_boundary;
    assign din_ready   = enable & ~reset & at_boundary;
    assign transfer    = din_valid & din_ready;

`ifdef SER_IDLE_PRBS_EN
    logic unused_idle_word;
    assign unused_idle_word = ^idleWord;

    // Advances only when an idle word is actually consumed.
    prbs7_word_gen #(
        .WIDTH   (WORDWIDTH)
    ) u_prbs (
        .clk     (bitCK),
        .reset   (reset),
        .advance (load & ~transfer),
        .word    (idle_src)
    );
`else
    assign idle_src = idleWord;
`endif

    // NOTE: the shift register is reset like any other flop (it is not a
    // memory array) because sout is read straight from it and must be 0
    // after reset.
    always_ff @(posedge bitCK) begin
        if (reset) begin
            cnt    <= LAST_SLOT;
            r      <= '0;
            mode   <= ORDER_LSB;
            idle_q <= 1'b0;
            primed <= 1'b0;
        end else if (load) begin
            cnt    <= '0;
            mode   <= bit_order_e'(msbFirst);
            primed <= 1'b1;
            if (transfer) begin
                r      <= din;
                idle_q <= 1'b0;
            end else begin
                r      <= idle_src;
                idle_q <= 1'b1;
            end
        end else if (enable) begin
            cnt <= cnt + CW'(1);
            // Shift toward the output end; zeros fill the vacated bits.
            if (mode == ORDER_MSB) begin
                r <= r << LANES;
            end else begin
                r <= r >> LANES;
            end
        end
    end

    // NOTE: sout gets its default before the mode test so no path through
    // the block leaves it unassigned, which would infer a latch.
    always_comb begin
        sout = r[LANES-1:0];
        if (mode == ORDER_MSB) begin
            sout = r[WORDWIDTH-1 -: LANES];
        end
    end

    // primed keeps wordStart low after reset when N == 1 (cnt is 0 there).
    assign wordStart  = primed & (cnt == '0);
    assign wordIsIdle = idle_q;

endmodule : multi_lane_serializer

// File: tb/tb_multi_lane_serializer.sv
// -----------------------------------------------------------------------------
// tb_multi_lane_serializer
// Two serializers share one stimulus stream: u1 (WORDWIDTH 8, LANES 1) and
// u2 (WORDWIDTH 8, LANES 2). A word-level model per instance turns each
// accepted or idle word into its list of expected slots; a compare process
// checks every output of both instances on every falling edge. Directed
// scenarios add literal expectations on top of that.
// Define SER_IDLE_PRBS_EN for the PRBS idle build.
// -----------------------------------------------------------------------------
module tb_multi_lane_serializer;

    typedef struct packed {
        logic [1:0] s;
        logic       ws;
        logic       idle;
    } slot_t;

    logic       bitCK = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] din;
    logic       din_valid;
    logic       msbFirst;
    logic [7:0] idleWord;

    logic       rdy1, ws1, idl1;
    logic [0:0] sout1;
    logic       rdy2, ws2, idl2;
    logic [1:0] sout2;

    int  total = 0;
    int  bad   = 0;
    bit  chk_on = 1'b0;
    bit  prbs_bits [8192];

    always #5 bitCK = ~bitCK;

    multi_lane_serializer #(.WORDWIDTH(8), .LANES(1)) u1 (
        .bitCK(bitCK), .reset(reset), .enable(enable), .din(din),
        .din_valid(din_valid), .din_ready(rdy1), .msbFirst(msbFirst),
        .idleWord(idleWord), .sout(sout1), .wordStart(ws1), .wordIsIdle(idl1)
    );

    multi_lane_serializer #(.WORDWIDTH(8), .LANES(2)) u2 (
        .bitCK(bitCK), .reset(reset), .enable(enable), .din(din),
        .din_valid(din_valid), .din_ready(rdy2), .msbFirst(msbFirst),
        .idleWord(idleWord), .sout(sout2), .wordStart(ws2), .wordIsIdle(idl2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge bitCK);
        #1;
    endtask

    // Word-level model: at every enabled edge with no slots pending, a new
    // word (offered data, else the idle source) is expanded into its N slots;
    // every enabled edge then moves the next slot onto the output.
    for (genvar g = 0; g < 2; g++) begin : mdl
        localparam int         L     = g + 1;
        localparam int         NS    = 8 / L;
        localparam logic [1:0] LMASK = (L == 1) ? 2'b01 : 2'b11;

        slot_t q[$];
        slot_t cur      = '0;
        bit    empty    = 1'b1;
        int    prbs_ptr = 0;
        int    xfer_obs = 0;
        logic  rdy_seen;

        assign rdy_seen = (g == 0) ? rdy1 : rdy2;

        always @(posedge bitCK) begin
            logic [7:0] w;
            logic [7:0] sl;
            logic       idl;
            if (din_valid && rdy_seen) xfer_obs++;
            if (reset) begin
                q.delete();
                cur      = '0;
                empty    = 1'b1;
                prbs_ptr = 0;
            end else if (enable) begin
                if (q.size() == 0) begin
                    if (din_valid) begin
                        w   = din;
                        idl = 1'b0;
                    end else begin
                        idl = 1'b1;
`ifdef SER_IDLE_PRBS_EN
                        for (int i = 0; i < 8; i++) w[i] = prbs_bits[prbs_ptr + i];
                        prbs_ptr += 8;
`else
                        w = idleWord;
`endif
                    end
                    for (int j = 0; j < NS; j++) begin
                        if (msbFirst) sl = w >> (8 - (j + 1) * L);
                        else          sl = w >> (j * L);
                        q.push_back('{s: sl[1:0] & LMASK, ws: (j == 0), idle: idl});
                    end
                end
                cur   = q.pop_front();
                empty = (q.size() == 0);
            end
        end
    end

    always @(negedge bitCK) begin
        if (chk_on) begin
            check("u1 sout",       32'(sout1), 32'(mdl[0].cur.s));
            check("u1 wordStart",  32'(ws1),   32'(mdl[0].cur.ws));
            check("u1 wordIsIdle", 32'(idl1),  32'(mdl[0].cur.idle));
            check("u1 din_ready",  32'(rdy1),  32'(enable & ~reset & mdl[0].empty));
            check("u2 sout",       32'(sout2), 32'(mdl[1].cur.s));
            check("u2 wordStart",  32'(ws2),   32'(mdl[1].cur.ws));
            check("u2 wordIsIdle", 32'(idl2),  32'(mdl[1].cur.idle));
            check("u2 din_ready",  32'(rdy2),  32'(enable & ~reset & mdl[1].empty));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         x0;
        int         cnt_a;
        logic [7:0] seq;
        logic [15:0] seq16;
        logic [7:0] pw;

        // PRBS7 reference: b[n] = b[n-7] ^ b[n-6], with seven 1s before b[0].
        for (int n = 0; n < 8192; n++) begin
            prbs_bits[n] = ((n >= 7) ? prbs_bits[n-7] : 1'b1) ^
                           ((n >= 6) ? prbs_bits[n-6] : 1'b1);
        end
        for (int i = 0; i < 8; i++) pw[i] = prbs_bits[i];
        check("prbs ref word0", 32'(pw), 32'h40);
        for (int i = 0; i < 8; i++) pw[i] = prbs_bits[8 + i];
        check("prbs ref word1", 32'(pw), 32'h30);

        reset = 1'b1; enable = 1'b1; din = 8'hA5; din_valid = 1'b1;
        msbFirst = 1'b0; idleWord = 8'hBC;

        // Reset state.
        step();
        @(negedge bitCK);
        check("rst u1 sout",      32'(sout1), 32'h0);
        check("rst u2 sout",      32'(sout2), 32'h0);
        check("rst u1 wordStart", 32'(ws1),   32'h0);
        check("rst u1 idle",      32'(idl1),  32'h0);
        check("rst u1 ready",     32'(rdy1),  32'h0);
        check("rst u2 ready",     32'(rdy2),  32'h0);
        chk_on = 1'b1;
        step();
        reset = 1'b0;

        // 1: 8'hA5 LSB first on u1.
        @(negedge bitCK);
        check("t1 u1 ready before load", 32'(rdy1), 32'h1);
        check("t1 u2 ready before load", 32'(rdy2), 32'h1);
        step();
        din_valid = 1'b0;
        seq = '0; cnt_a = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge bitCK);
            seq   = {seq[6:0], sout1};
            cnt_a += int'(rdy1);
            if (i == 0) check("t1 u1 wordStart", 32'(ws1), 32'h1);
            step();
        end
        check("t1 u1 bit stream", 32'(seq), 32'b1010_0101);
        check("t1 u1 ready count", 32'(cnt_a), 32'h1);

        // 2: 8'hC6 MSB first on u2.
        reset = 1'b1; msbFirst = 1'b1; din = 8'hC6; din_valid = 1'b1;
        step();
        reset = 1'b0;
        step();
        din_valid = 1'b0;
        seq = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge bitCK);
            if (i < 4) seq = {seq[5:0], sout2};
            if (i == 0 || i == 4) check("t2 u2 wordStart", 32'(ws2), 32'h1);
            step();
        end
        check("t2 u2 slices", 32'(seq), 32'b11_00_01_10);

        // 3: idle words back to back.
        reset = 1'b1; msbFirst = 1'b0; din_valid = 1'b0; idleWord = 8'hBC;
        step();
        reset = 1'b0;
        x0 = mdl[0].xfer_obs + mdl[1].xfer_obs;
        step();
        cnt_a = 0; seq16 = '0;
        for (int i = 0; i < 24; i++) begin
            @(negedge bitCK);
            cnt_a += int'(idl1);
            if (i < 16) seq16 = {sout1, seq16[15:1]};
            step();
        end
        check("t3 u1 idle slots", 32'(cnt_a), 32'd24);
`ifndef SER_IDLE_PRBS_EN
        check("t3 u1 idle stream", 32'(seq16), 32'hBCBC);
`endif
        check("t3 transfers", 32'(mdl[0].xfer_obs + mdl[1].xfer_obs - x0), 32'h0);

        // 4: enable low for 5 cycles in the middle of 8'h3C.
        reset = 1'b1; din = 8'h3C; din_valid = 1'b1;
        step();
        reset = 1'b0;
        step();
        din_valid = 1'b0;
        seq = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge bitCK);
            seq = {sout1, seq[7:1]};
            step();
        end
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge bitCK);
            check("t4 u1 frozen sout", 32'(sout1), 32'h1);
            check("t4 u1 ready low",   32'(rdy1),  32'h0);
            check("t4 u2 ready low",   32'(rdy2),  32'h0);
            step();
        end
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge bitCK);
            seq = {sout1, seq[7:1]};
            step();
        end
        check("t4 u1 resumed word", 32'(seq), 32'h3C);

        // 5: reset at slot 3 of 8'h5A.
        reset = 1'b1; din = 8'h5A; din_valid = 1'b1;
        step();
        reset = 1'b0;
        step();
        din_valid = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        @(negedge bitCK);
        check("t5 u1 ready in reset", 32'(rdy1), 32'h0);
        check("t5 u2 ready in reset", 32'(rdy2), 32'h0);
        step();
        @(negedge bitCK);
        check("t5 u1 sout cleared", 32'(sout1), 32'h0);
        check("t5 u2 sout cleared", 32'(sout2), 32'h0);
        check("t5 u1 wordStart",    32'(ws1),   32'h0);
        #2;
        reset = 1'b0; din = 8'h81; din_valid = 1'b1;
        #1;
        check("t5 u1 ready after release", 32'(rdy1), 32'h1);
        check("t5 u2 ready after release", 32'(rdy2), 32'h1);
        step();
        din_valid = 1'b0;
        @(negedge bitCK);
        check("t5 u1 first slot", 32'(sout1), 32'h1);
        check("t5 u1 wordStart",  32'(ws1),   32'h1);
        repeat (16) step();

        // 6: long idle stretch (PRBS stream in the PRBS build).
        reset = 1'b1; din_valid = 1'b0; msbFirst = 1'b0;
        step();
        reset = 1'b0;
        step();
        seq = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge bitCK);
            seq = {sout1, seq[7:1]};
            step();
        end
`ifdef SER_IDLE_PRBS_EN
        check("t6 u1 first idle word", 32'(seq), 32'h40);
`else
        check("t6 u1 first idle word", 32'(seq), 32'hBC);
`endif
        repeat (126 * 8) step();

        @(negedge bitCK);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_multi_lane_serializer
